// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage data-memory port with byte strobes, load extension and stall control
//   clk, rst          clock and synchronous active-high reset
//   mem_valid         EX/MEM holds a live instruction
//   mem_MR, mem_MW    load / store request
//   mem_funct3        access size and sign (RV32I)
//   mem_alu_result    byte address
//   mem_store_data    store source
//   dmem_*            registered request/acknowledge port to data memory
//   mem_read_data     registered, formatted load result to MEM/WB
//   mem_stall         combinational stall for all pipeline enables
//   access_err        one-cycle pulse on a misaligned or malformed access
//   timeout_err       one-cycle pulse when memory never acknowledges
module mem_access_unit #(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_valid,
   input  logic        mem_MR,
   input  logic        mem_MW,
   input  logic [2:0]  mem_funct3,
   input  logic [31:0] mem_alu_result,
   input  logic [31:0] mem_store_data,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic [3:0]  dmem_wstrb,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata,
   output logic [31:0] mem_read_data,
   output logic        mem_stall,
   output logic        access_err,
   output logic        timeout_err
);
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   state_t      state;
   logic [7:0]  cnt;
   logic [7:0]  cnt_inc;
   logic [1:0]  lane;
   logic [2:0]  ld_f3;
   logic [1:0]  a;
   logic        req_any, f3_ok, align_ok, fault, legal;
   logic [3:0]  wstrb_n;
   logic [31:0] wdata_n, sh, ld_fmt;
   assign a        = mem_alu_result[1:0];
   assign req_any  = mem_valid & (mem_MR | mem_MW);
   assign f3_ok    = mem_MW ? (mem_funct3 inside {3'b000, 3'b001, 3'b010})
                            : (mem_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
   assign align_ok = mem_funct3[1:0] == 2'b01 ? !a[0] : mem_funct3[1:0] == 2'b10 ? a == 2'b00 : 1'b1;
   assign fault    = req_any & ((mem_MR & mem_MW) | !f3_ok | !align_ok);
   assign legal    = req_any & !fault;
   assign mem_stall = (state == IDLE && legal) || state == BUSY;
   assign cnt_inc  = cnt + 8'd1;
   // loads drive no strobes; stores replicate data into every lane so the strobe alone selects bytes
   assign wstrb_n = !mem_MW ? 4'b0000 : mem_funct3[1:0] == 2'b00 ? 4'b0001 << a
                  : mem_funct3[1:0] == 2'b01 ? (a[1] ? 4'b1100 : 4'b0011) : 4'b1111;
   assign wdata_n = mem_funct3[1:0] == 2'b00 ? {4{mem_store_data[7:0]}}
                  : mem_funct3[1:0] == 2'b01 ? {2{mem_store_data[15:0]}} : mem_store_data;
   // lane and funct3 are captured at issue so formatting never depends on the frozen EX/MEM inputs
   assign sh     = dmem_rdata >> {lane, 3'b000};
   assign ld_fmt = ld_f3 == 3'b000 ? {{24{sh[7]}}, sh[7:0]}
                 : ld_f3 == 3'b001 ? {{16{sh[15]}}, sh[15:0]}
                 : ld_f3 == 3'b100 ? {24'd0, sh[7:0]}
                 : ld_f3 == 3'b101 ? {16'd0, sh[15:0]} : dmem_rdata;
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         cnt           <= 8'd0;
         lane          <= 2'b00;
         ld_f3         <= 3'b000;
         dmem_req      <= 1'b0;
         dmem_we       <= 1'b0;
         dmem_addr     <= 32'd0;
         dmem_wdata    <= 32'd0;
         dmem_wstrb    <= 4'd0;
         mem_read_data <= 32'd0;
         access_err    <= 1'b0;
         timeout_err   <= 1'b0;
      end else begin
         access_err  <= 1'b0;
         timeout_err <= 1'b0;
         case (state)
            IDLE: begin
               if (legal) begin
                  dmem_req   <= 1'b1;
                  dmem_we    <= mem_MW;
                  dmem_addr  <= {mem_alu_result[31:2], 2'b00};
                  dmem_wdata <= wdata_n;
                  dmem_wstrb <= wstrb_n;
                  lane       <= a;
                  ld_f3      <= mem_funct3;
                  cnt        <= 8'd0;
                  state      <= BUSY;
               end else if (fault) begin
                  access_err <= 1'b1;
               end
            end
            BUSY: begin
               cnt <= cnt_inc;
               // an ack arriving on the expiry cycle still wins over the timeout
               if (dmem_ack) begin
                  dmem_req <= 1'b0;
                  if (!dmem_we) mem_read_data <= ld_fmt;
                  state <= DONE;
               end else if (cnt_inc == 8'(TIMEOUT)) begin
                  dmem_req    <= 1'b0;
                  timeout_err <= 1'b1;
                  if (!dmem_we) mem_read_data <= 32'd0;
                  state <= DONE;
               end
            end
            DONE: begin
               cnt   <= 8'd0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

- Drives the data-memory port for the MEM stage.
- Sits between the EX/MEM register outputs and the MEM/WB register's `mem_read_data` input.
- Turns load/store requests into a request/acknowledge transaction with byte strobes, and sign- or zero-extends load data.
- Holds the pipeline stalled until memory acknowledges, a timeout expires, or an access fault is detected.

## Interface

Parameters:
- TIMEOUT, 255: BUSY cycles without `dmem_ack` before the access is abandoned (1..255, 8-bit counter).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- mem_valid  in  1  EX/MEM holds a live instruction
- mem_MR  in  1  load request
- mem_MW  in  1  store request
- mem_funct3  in  3  access size/sign (RV32I encoding)
- mem_alu_result  in  32  byte address
- mem_store_data  in  32  store source (rs2)
- dmem_req  out  1  memory request, registered
- dmem_we  out  1  1 = write, registered
- dmem_addr  out  32  word address {addr[31:2],2'b00}, registered
- dmem_wdata  out  32  lane-replicated store data, registered
- dmem_wstrb  out  4  byte strobes, registered
- dmem_ack  in  1  memory completion, single-cycle pulse
- dmem_rdata  in  32  read word, valid with dmem_ack
- mem_read_data  out  32  formatted load result to MEM/WB, registered
- mem_stall  out  1  combinational; 1 = hold all pipeline enables low
- access_err  out  1  one-cycle pulse: misaligned, illegal funct3, or MR&MW both set
- timeout_err  out  1  one-cycle pulse: TIMEOUT expired

## Operation

- FSM states: IDLE, BUSY, DONE.
- Reset: state=IDLE, counter=0, and every output register is 0 (`dmem_req`, `dmem_we`, `dmem_addr`, `dmem_wdata`, `dmem_wstrb`, `mem_read_data`, `access_err`, `timeout_err`).
- IDLE, when `mem_valid`, (MR|MW), and the access is legal:
  - Load `dmem_addr`, `dmem_we`=MW, `dmem_wdata` and `dmem_wstrb`.
  - Set `dmem_req`=1 and go to BUSY.
- IDLE, when the access is illegal:
  - Pulse `access_err`, issue no request and stay in IDLE.
  - `mem_read_data` is unchanged.
- BUSY:
  - `dmem_req` and all `dmem_*` outputs are held stable.
  - The counter increments every cycle.
  - On `dmem_ack`: clear `dmem_req` and go to DONE. For a load, also register the formatted `dmem_rdata` into `mem_read_data`.
  - When the counter reaches TIMEOUT without an ack: clear `dmem_req`, pulse `timeout_err`, set `mem_read_data`=0 (loads only) and go to DONE.
- DONE: clear the counter and go to IDLE unconditionally. The pipeline advances at the end of this cycle.
- Legality:
  - funct3 ∈ {000,001,010,100,101} for loads; funct3 ∈ {000,001,010} for stores.
  - Halfword accesses need addr[0]=0; word accesses need addr[1:0]=0.
  - MR and MW must not both be set.
- Store formatting:
  - SB: wstrb = 4'b0001<<addr[1:0], wdata = {4{data[7:0]}}.
  - SH: wstrb = addr[1] ? 1100 : 0011, wdata = {2{data[15:0]}}.
  - SW: wstrb = 1111, wdata = data.
- Load formatting: select the lane by addr[1:0] (held internally from issue).
  - LB/LH: sign-extend to 32 bits.
  - LBU/LHU: zero-extend to 32 bits.
  - LW: pass the word through.
- `mem_read_data` changes only on a load completion or a load timeout. Stores and faults leave it unchanged.

## Timing

- `mem_stall` is 1 in these cases, and 0 otherwise (including DONE and fault cycles):
  - In IDLE with a legal access presented.
  - In BUSY.
- Zero-wait memory (ack in the first BUSY cycle) takes 3 cycles per access: IDLE (stalled), BUSY (stalled), DONE (released).
- Each wait cycle of memory adds one stalled BUSY cycle.
- `dmem_ack` received in IDLE or DONE is ignored.
- An ack in the same cycle the counter reaches TIMEOUT counts as the ack; `timeout_err` stays 0.
- rst during BUSY: `dmem_req`=0 at the next edge, and all reset values apply.
- The instruction in EX/MEM is frozen by the stall, so its inputs must be stable from IDLE detection through DONE.
- A back-to-back access in EX/MEM is first seen in the IDLE cycle after DONE.

## Test plan

- Load LW at addr 0x100, memory acks 2 cycles after `dmem_req` rises.
  - `dmem_addr`=0x100, `dmem_wstrb`=0000, `dmem_we`=0.
  - `mem_stall` is high for 4 cycles.
  - `mem_read_data`=0x12345678 one cycle after the ack.
- LB at addr 0x103 with rdata 0x80FF0011 gives `mem_read_data`=0xFFFFFF80.
  - LBU at the same address gives 0x00000080.
  - LHU at 0x102 with the same rdata gives 0x000080FF.
- SB at addr 0x0D with data 0xAABBCCDD: `dmem_wstrb`=0010, `dmem_wdata`=0xDDDDDDDD, `dmem_addr`=0x0C.
  - SH at 0x0E: `dmem_wstrb`=1100, `dmem_wdata`=0xCCDDCCDD.
- LW at 0x102: `access_err`=1 for one cycle, no `dmem_req`, `mem_stall`=0, `mem_read_data` unchanged.
  - funct3=011 load: same response.
- TIMEOUT=4, memory never acks: `dmem_req` high for 4 cycles, then `timeout_err` pulses, `mem_read_data`=0, and FSM returns to IDLE through DONE.
- rst asserted in the 2nd BUSY cycle: all outputs are 0 next cycle.
  - A later LW completes normally.
  - A stray `dmem_ack` while IDLE changes nothing.
